// File: rtl/sram_bus_ctrl_if.sv
// CPU-side request/response bus of the SRAM controller.
// Latency: n/a (signal bundle only).
// Backpressure: master must hold off while busy=1; requests seen while busy are dropped.
//   req/we/addr/wdata : request, qualified by req, sampled only when busy=0
//   rdata/ack/busy    : read data, one-cycle completion pulse, transaction in flight
interface sram_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_bus_ctrl.sv
// Turns single-cycle CPU read/write requests into timed async-SRAM cycles with registered strobes.
// Latency: read req->ack = WAIT_RD+1 cycles, write req->ack = SETUP+WAIT_WR+HOLD+1 cycles.
// Backpressure: busy is high from the cycle after acceptance through ack; req is ignored meanwhile.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : CPU request/response bus (sram_bus_ctrl_if)
//   sram_addr/cen/oen/wen : address and active-low strobes to the SRAM, all from flops
//   sram_oe/dout/din    : data pad buffer control, output data, input data
// Optional macro SRAM_BUS_BANK_EN adds bank_we/bank_wdata, a 3-bit bank register
// that supplies sram_addr[18:16]; without it those address bits are 0.
module sram_bus_ctrl #(
  parameter int SETUP   = 1,  // min 1
  parameter int WAIT_WR = 2,  // min 1
  parameter int HOLD    = 1,  // 0 skips WR_HOLD
  parameter int WAIT_RD = 2   // min 1
) (
  input  logic              clk,
  input  logic              reset_n,
  sram_bus_ctrl_if.slave    bus,
`ifdef SRAM_BUS_BANK_EN
  input  logic              bank_we,
  input  logic [2:0]        bank_wdata,
`endif
  output logic [18:0]       sram_addr,
  output logic              sram_cen,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic              sram_oe,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din
);

  localparam int MAX_AB = (SETUP > WAIT_WR) ? SETUP : WAIT_WR;
  localparam int MAX_CD = (HOLD > WAIT_RD) ? HOLD : WAIT_RD;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

  // Counter reload values: a state lasting N cycles loads N-1 and exits at 0.
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP - 1);
  localparam logic [CW-1:0] WR_LD    = CW'(WAIT_WR - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'((HOLD > 0) ? HOLD - 1 : 0);
  localparam logic [CW-1:0] RD_LD    = CW'(WAIT_RD - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    rdata_q;
  logic          ack_q;
  logic          busy_q;
  logic [2:0]    addr_hi;

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;

`ifdef SRAM_BUS_BANK_EN
  logic [2:0] bank_q;

  // Loads in any state; the address only picks it up at acceptance, so a
  // mid-transaction bank write never disturbs the cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= 3'd0;
    end else if (bank_we) begin
      bank_q <= bank_wdata;
    end
  end

  assign addr_hi = bank_q;
`else
  assign addr_hi = 3'd0;
`endif

  // Strobes are set on the transition into each state so every pad output is
  // a flop; an async reset forces wen high directly, truncating any pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sram_cen  <= 1'b1;
      sram_oen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_oe   <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      rdata_q   <= 8'h00;
      sram_addr <= 19'h0;
      sram_dout <= 8'h00;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            sram_addr <= {addr_hi, bus.addr};
            sram_dout <= bus.wdata;
            busy_q    <= 1'b1;
            sram_cen  <= 1'b0;
            if (bus.we) begin
              state   <= WR_SETUP;
              cnt     <= SETUP_LD;
              sram_oe <= 1'b1;
            end else begin
              state    <= RD;
              cnt      <= RD_LD;
              sram_oen <= 1'b0;
            end
          end
        end

        RD: begin
          if (cnt == '0) begin
            rdata_q  <= sram_din;
            state    <= ACK;
            cnt      <= '0;
            sram_cen <= 1'b1;
            sram_oen <= 1'b1;
            ack_q    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_SETUP: begin
          if (cnt == '0) begin
            state    <= WR_PULSE;
            cnt      <= WR_LD;
            sram_wen <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_PULSE: begin
          if (cnt == '0) begin
            sram_wen <= 1'b1;
            if (HOLD > 0) begin
              state <= WR_HOLD;
              cnt   <= HOLD_LD;
            end else begin
              state    <= ACK;
              cnt      <= '0;
              sram_cen <= 1'b1;
              sram_oe  <= 1'b0;
              ack_q    <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_HOLD: begin
          if (cnt == '0) begin
            state    <= ACK;
            cnt      <= '0;
            sram_cen <= 1'b1;
            sram_oe  <= 1'b0;
            ack_q    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ACK: begin
          // Requests arriving in the ack cycle are dropped here.
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed, table-driven bench for sram_bus_ctrl with default timing parameters.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_sram_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] sram_addr;
  logic        sram_cen, sram_oen, sram_wen, sram_oe;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din = 8'h00;
`ifdef SRAM_BUS_BANK_EN
  logic        bank_we = 1'b0;
  logic [2:0]  bank_wdata = 3'd0;
`endif

  int errors = 0;
  int checks = 0;

  sram_bus_ctrl_if bus_if ();

  sram_bus_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus_if),
`ifdef SRAM_BUS_BANK_EN
    .bank_we   (bank_we),
    .bank_wdata(bank_wdata),
`endif
    .sram_addr (sram_addr),
    .sram_cen  (sram_cen),
    .sram_oen  (sram_oen),
    .sram_wen  (sram_wen),
    .sram_oe   (sram_oe),
    .sram_dout (sram_dout),
    .sram_din  (sram_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        cen, oen, wen, oe, ack, busy;
    logic [18:0] saddr;
    logic [7:0]  dout;
    logic [7:0]  rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic req, logic we, logic [15:0] addr, logic [7:0] wdata,
                              logic [7:0] din, logic cen, logic oen, logic wen, logic oe,
                              logic ack, logic busy, logic [18:0] saddr, logic [7:0] dout,
                              logic [7:0] rdata);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.din = din;
    v.cen = cen; v.oen = oen; v.wen = wen; v.oe = oe; v.ack = ack; v.busy = busy;
    v.saddr = saddr; v.dout = dout; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, row, got, exp);
    end
  endtask

  task automatic check_idle_pads(input string tag, input int row);
    chk({tag, "_cen"}, row, {31'b0, sram_cen}, 32'd1);
    chk({tag, "_oen"}, row, {31'b0, sram_oen}, 32'd1);
    chk({tag, "_wen"}, row, {31'b0, sram_wen}, 32'd1);
    chk({tag, "_oe"},  row, {31'b0, sram_oe},  32'd0);
    chk({tag, "_ack"}, row, {31'b0, bus_if.ack},  32'd0);
    chk({tag, "_busy"}, row, {31'b0, bus_if.busy}, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [15:0] addr,
                       input logic [7:0] wdata);
    bus_if.req   = req;
    bus_if.we    = we;
    bus_if.addr  = addr;
    bus_if.wdata = wdata;
  endtask

  initial begin
    drive(1'b0, 1'b0, 16'h0000, 8'h00);

    // Each row: inputs present at a rising edge, outputs expected just after it.
    //            req we addr     wdata  din    cen oen wen oe ack busy saddr      dout   rdata
    tbl.push_back(mk(1, 1, 16'h1234, 8'hA5, 8'h00, 0, 1, 1, 1, 0, 1, 19'h01234, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 19'h01234, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 19'h01234, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 19'h01234, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 1, 0, 1, 1, 19'h01234, 8'hA5, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 19'h01234, 8'hA5, 8'h00));
    // read 0xFFFC
    tbl.push_back(mk(1, 0, 16'hFFFC, 8'h00, 8'h5A, 0, 0, 1, 0, 0, 1, 19'h0FFFC, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h5A, 0, 0, 1, 0, 0, 1, 19'h0FFFC, 8'h00, 8'h00));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h5A, 1, 1, 1, 0, 1, 1, 19'h0FFFC, 8'h00, 8'h5A));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h33, 1, 1, 1, 0, 0, 0, 19'h0FFFC, 8'h00, 8'h5A));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h77, 1, 1, 1, 0, 0, 0, 19'h0FFFC, 8'h00, 8'h5A));
    // read 0x0042 with requests held during busy and in the ack cycle
    tbl.push_back(mk(1, 0, 16'h0042, 8'h00, 8'h11, 0, 0, 1, 0, 0, 1, 19'h00042, 8'h00, 8'h5A));
    tbl.push_back(mk(1, 1, 16'hBEEF, 8'h99, 8'h11, 0, 0, 1, 0, 0, 1, 19'h00042, 8'h00, 8'h5A));
    tbl.push_back(mk(1, 1, 16'hBEEF, 8'h99, 8'hC3, 1, 1, 1, 0, 1, 1, 19'h00042, 8'h00, 8'hC3));
    tbl.push_back(mk(1, 1, 16'h0100, 8'h3C, 8'h00, 1, 1, 1, 0, 0, 0, 19'h00042, 8'h00, 8'hC3));
    // request in the cycle after ack is accepted
    tbl.push_back(mk(1, 1, 16'h0100, 8'h3C, 8'h00, 0, 1, 1, 1, 0, 1, 19'h00100, 8'h3C, 8'hC3));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 19'h00100, 8'h3C, 8'hC3));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 19'h00100, 8'h3C, 8'hC3));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 19'h00100, 8'h3C, 8'hC3));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 1, 0, 1, 1, 19'h00100, 8'h3C, 8'hC3));
    tbl.push_back(mk(0, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 1, 0, 0, 0, 19'h00100, 8'h3C, 8'hC3));

    // Reset held while the clock runs
    repeat (3) @(posedge clk);
    #1;
    check_idle_pads("rst", 0);
    chk("rst_rdata", 0, {24'b0, bus_if.rdata}, 32'h0);
    chk("rst_addr",  0, {13'b0, sram_addr},    32'h0);
    chk("rst_dout",  0, {24'b0, sram_dout},    32'h0);

    @(negedge clk);
    reset_n = 1'b1;
    step();
    check_idle_pads("post_rst", 0);
    step();
    check_idle_pads("post_rst", 1);

    // Vector table
    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      sram_din = tbl[i].din;
      step();
      chk("cen",   i, {31'b0, sram_cen},     {31'b0, tbl[i].cen});
      chk("oen",   i, {31'b0, sram_oen},     {31'b0, tbl[i].oen});
      chk("wen",   i, {31'b0, sram_wen},     {31'b0, tbl[i].wen});
      chk("oe",    i, {31'b0, sram_oe},      {31'b0, tbl[i].oe});
      chk("ack",   i, {31'b0, bus_if.ack},   {31'b0, tbl[i].ack});
      chk("busy",  i, {31'b0, bus_if.busy},  {31'b0, tbl[i].busy});
      chk("addr",  i, {13'b0, sram_addr},    {13'b0, tbl[i].saddr});
      chk("dout",  i, {24'b0, sram_dout},    {24'b0, tbl[i].dout});
      chk("rdata", i, {24'b0, bus_if.rdata}, {24'b0, tbl[i].rdata});
      chk("oe_oen_excl", i, {31'b0, sram_oe & ~sram_oen}, 32'd0);
    end

    // Asynchronous reset in the middle of the write strobe
    drive(1'b1, 1'b1, 16'h0777, 8'h44);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    chk("mid_wen_low", 0, {31'b0, sram_wen}, 32'd0);
    #1;
    reset_n = 1'b0;
    #1;
    // Still well before the next rising edge
    check_idle_pads("async_rst", 0);
    chk("async_rst_addr",  0, {13'b0, sram_addr},    32'h0);
    chk("async_rst_rdata", 0, {24'b0, bus_if.rdata}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_idle_pads("after_rst", k);
    end

`ifdef SRAM_BUS_BANK_EN
    // Bank register supplies the upper address bits at acceptance
    bank_we = 1'b1;
    bank_wdata = 3'd5;
    step();
    bank_we = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 8'h00);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("bank_addr", 0, {13'b0, sram_addr}, 32'h50010);
    bank_we = 1'b1;
    bank_wdata = 3'd2;
    step();
    bank_we = 1'b0;
    chk("bank_addr_stable", 0, {13'b0, sram_addr}, 32'h50010);
    step();
    chk("bank_ack", 0, {31'b0, bus_if.ack}, 32'd1);
    step();
    drive(1'b1, 1'b0, 16'h0020, 8'h00);
    step();
    drive(1'b0, 1'b0, 16'h0000, 8'h00);
    chk("bank_addr_next", 0, {13'b0, sram_addr}, 32'h20020);
    repeat (3) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
- Sits between the tst_6502 CPU bus and the external async SRAM pads (data SB_IO buffers, A[18:0], CEn/WEn/OEn).
- Converts single-cycle CPU read/write requests into timed SRAM cycles: configurable setup, strobe width and hold.
- Registered, glitch-free strobes.
- Returns read data with a one-cycle ack pulse.

Parameters:
- SETUP, 1: cycles (min 1) with CEn low, data driven and WEn high before the write strobe.
- WAIT_WR, 2: cycles (min 1) WEn is held low.
- HOLD, 1: cycles (0 allowed) data stays driven after WEn rises.
- WAIT_RD, 2: cycles (min 1) CEn/OEn are low before read data is sampled.

Ports:
- clk  in  1  system clock (ring-oscillator or PLL domain)
- reset_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only when busy=0
- we  in  1  1=write, 0=read; qualified by req
- addr  in  16  CPU address; qualified by req
- wdata  in  8  write data; qualified by req
- rdata  out  8  read data; valid from the ack cycle until the next read completes
- ack  out  1  one-cycle completion pulse, for both reads and writes
- busy  out  1  high from the cycle after acceptance through the ack cycle
- sram_addr  out  19  to A0..A18
- sram_cen  out  1  chip enable, active low
- sram_oen  out  1  output enable, active low
- sram_wen  out  1  write enable, active low
- sram_oe  out  1  pad data output enable, 1 = FPGA drives D[7:0]
- sram_dout  out  8  pad data out
- sram_din  in  8  pad data in

Behaviour:
Reset (asserting reset_n low, any state, takes effect immediately without a clock):
- cen=oen=wen=1; sram_oe=0; ack=0; busy=0.
- rdata=0; sram_addr=0; sram_dout=0; FSM=IDLE.
- Reset during WR_PULSE truncates the strobe; no glitch low on wen is allowed.

FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- All pad outputs come from flops; no combinational path from req to pads.
- A down-counter reloads on every state entry.

IDLE:
- Outputs: cen=1, oen=1, wen=1, sram_oe=0.
- On req=1: latch addr into sram_addr[15:0] and wdata into sram_dout; busy=1 next cycle.
- Next state WR_SETUP if we=1, else RD.

RD:
- Outputs: cen=0, oen=0, sram_oe=0.
- Lasts WAIT_RD cycles.
- On the last cycle, sram_din is registered into rdata, then go to ACK.

WR_SETUP:
- Outputs: cen=0, oen=1, wen=1, sram_oe=1.
- Lasts SETUP cycles, then go to WR_PULSE.

WR_PULSE:
- wen=0, everything else as in WR_SETUP.
- Lasts exactly WAIT_WR cycles.

WR_HOLD:
- Outputs: wen=1, sram_oe=1, cen=0.
- Lasts HOLD cycles; when HOLD=0 the state is skipped.

ACK:
- Outputs: ack=1, cen=1, oen=1, wen=1, sram_oe=0.
- Next state IDLE; busy drops in the IDLE cycle.

Latency:
- Read: req to ack = WAIT_RD+1 cycles.
- Write: req to ack = SETUP+WAIT_WR+HOLD+1 cycles.

Invariants:
- sram_oe=1 and oen=0 are never true together.
- wen is low only in WR_PULSE.
- sram_addr and sram_dout are stable throughout a transaction.

Request rules:
- req while busy=1, including the ack cycle: ignored, no state change.
- The next req is accepted no earlier than the cycle after ack.

Optional Feature:
Macro SRAM_BUS_BANK_EN.

Defined:
- Adds ports bank_we (in, 1) and bank_wdata (in, 3).
- A 3-bit bank register (reset 0) loads when bank_we=1 in any state.
- sram_addr[18:16] is latched from the bank register at request acceptance, so a bank write mid-transaction affects only later transactions.

Undefined:
- The bank ports are absent.
- sram_addr[18:16] is constant 0.

Test Plan:
1. Hold reset_n=0 and toggle clk -> cen/oen/wen=1, sram_oe=0, busy=0, ack=0, rdata=0x00. Release reset -> outputs unchanged, FSM idle.
2. Defaults; write req addr=0x1234, wdata=0xA5 -> sram_addr=0x01234, sram_dout=0xA5. Then cen low 4 cycles, wen low exactly cycles 2-3, sram_oe high 4 cycles, ack 5 cycles after req, no overlap of oen=0 with sram_oe=1.
3. Read req addr=0xFFFC with sram_din=0x5A -> cen/oen low 2 cycles, ack 3 cycles after req, rdata=0x5A held after ack while sram_din changes.
4. req pulses during busy and in the ack cycle -> ignored, exactly one ack. A req one cycle after ack is accepted.
5. Assert reset_n mid-WR_PULSE -> wen, cen and sram_oe return high/0 asynchronously before the next clk edge. After release, IDLE with no ack.
6. Build with SRAM_BUS_BANK_EN; bank_wdata=5, then read 0x0010 -> sram_addr=0x50010. Bank write to 2 mid-transaction -> current address unchanged, next transaction uses 0x2xxxx.
